// File: rtl/osw_switch_model.sv
// osw_switch_model: behavioural responder for a latching optical switch.
// The block consumes the two drive lanes from the switch controller and
// requires a qualified single-lane drive before it actuates. It then emulates
// the settle time and contact bounce, and reports the latched position on two
// status lines. The status line for the target position stays high until the
// next actuation starts.
module osw_switch_model #(
  parameter int unsigned MIN_DRIVE_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES    = 8192,
  parameter int unsigned BOUNCE_TOGGLES   = 4,
  parameter int unsigned BOUNCE_PERIOD    = 16,
  parameter int unsigned CNT_WIDTH        = 20
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        osw_drive0,
  input  logic        osw_drive1,
  output logic        osw_status0,
  output logic        osw_status1,
  output logic        sw_position,
  output logic        pos_valid,
  output logic        sw_busy,
  output logic        drive_fault,
  output logic [15:0] act_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_BOUNCE = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] QUAL_LAST   = CNT_WIDTH'(MIN_DRIVE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(BOUNCE_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] TOGGLES     = CNT_WIDTH'(BOUNCE_TOGGLES);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] qual_q, qual_d;       // consecutive qualified drive samples
  logic                 lane_q, lane_d;       // lane of the current qualifying run (1 = drive1)
  logic [CNT_WIDTH-1:0] timer_q, timer_d;     // settle timer in MOVE, bounce period timer in BOUNCE
  logic [CNT_WIDTH-1:0] tog_q, tog_d;         // bounce toggles already performed
  logic                 status0_q, status0_d;
  logic                 status1_q, status1_d;
  logic                 pos_q, pos_d;
  logic                 pos_valid_q, pos_valid_d;
  logic                 busy_q, busy_d;
  logic                 fault_q, fault_d;
  logic [15:0]          act_count_q, act_count_d;

  logic single_lane;
  logic drive_lane;

  assign single_lane = osw_drive0 ^ osw_drive1;
  assign drive_lane  = osw_drive1;

  // Next-state and output logic for the qualify / move / bounce sequence.
  always_comb begin
    // NOTE: every variable gets its hold value first so that no path through the case infers a latch.
    state_d     = state_q;
    qual_d      = qual_q;
    lane_d      = lane_q;
    timer_d     = timer_q;
    tog_d       = tog_q;
    status0_d   = status0_q;
    status1_d   = status1_q;
    pos_d       = pos_q;
    pos_valid_d = pos_valid_q;
    busy_d      = busy_q;
    fault_d     = fault_q;
    act_count_d = act_count_q;

    if (osw_drive0 && osw_drive1) begin
      fault_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!single_lane) begin
          qual_d = '0;
        end else if ((qual_q != '0) && (drive_lane != lane_q)) begin
          // A lane change ends the run; this sample does not count toward the new lane.
          qual_d = '0;
        end else if (qual_q == QUAL_LAST) begin
          qual_d = '0;
          // The drive0 lane targets ON. A drive toward the position already latched has no effect.
          if (!(pos_valid_q && (pos_q == ~drive_lane))) begin
            state_d     = ST_MOVE;
            pos_d       = ~drive_lane;
            pos_valid_d = 1'b1;
            busy_d      = 1'b1;
            status0_d   = 1'b0;
            status1_d   = 1'b0;
            timer_d     = '0;
            if (act_count_q != 16'hFFFF) begin
              act_count_d = act_count_q + 16'd1;
            end
          end
        end else begin
          qual_d = qual_q + 1'b1;
          lane_d = drive_lane;
        end
      end

      ST_MOVE: begin
        qual_d = '0;
        if (timer_q == SETTLE_LAST) begin
          timer_d = '0;
          tog_d   = '0;
          if (pos_q) begin
            status0_d = 1'b1;
          end else begin
            status1_d = 1'b1;
          end
          if (BOUNCE_TOGGLES == 0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_BOUNCE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_BOUNCE: begin
        qual_d = '0;
        if (timer_q == PERIOD_LAST) begin
          timer_d = '0;
          if (tog_q == TOGGLES) begin
            // All bounces are done. The contact now settles high for good.
            if (pos_q) begin
              status0_d = 1'b1;
            end else begin
              status1_d = 1'b1;
            end
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            tog_d = tog_q + 1'b1;
            if (pos_q) begin
              status0_d = ~status0_q;
            end else begin
              status1_d = ~status1_q;
            end
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by areset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      qual_q      <= '0;
      lane_q      <= 1'b0;
      timer_q     <= '0;
      tog_q       <= '0;
      status0_q   <= 1'b0;
      status1_q   <= 1'b0;
      pos_q       <= 1'b0;
      pos_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      act_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the values that held before the edge.
      state_q     <= state_d;
      qual_q      <= qual_d;
      lane_q      <= lane_d;
      timer_q     <= timer_d;
      tog_q       <= tog_d;
      status0_q   <= status0_d;
      status1_q   <= status1_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
      act_count_q <= act_count_d;
    end
  end

  assign osw_status0 = status0_q;
  assign osw_status1 = status1_q;
  assign sw_position = pos_q;
  assign pos_valid   = pos_valid_q;
  assign sw_busy     = busy_q;
  assign drive_fault = fault_q;
  assign act_count   = act_count_q;

endmodule

// File: tb/tb_osw_switch_model.sv
// tb_osw_switch_model: directed scenarios followed by randomized drive
// patterns. Every cycle, the outputs are compared with a time-based reference
// model of the switch.
module tb_osw_switch_model;

  localparam int MIN  = 32;
  localparam int SET  = 64;
  localparam int TOG  = 4;
  localparam int PER  = 5;
  localparam int CW   = 12;
  localparam int MOTION_LEN = SET + ((TOG == 0) ? 0 : PER * (TOG + 1));

  logic        aclk;
  logic        areset;
  logic        osw_drive0;
  logic        osw_drive1;
  logic        osw_status0;
  logic        osw_status1;
  logic        sw_position;
  logic        pos_valid;
  logic        sw_busy;
  logic        drive_fault;
  logic [15:0] act_count;

  osw_switch_model #(
    .MIN_DRIVE_CYCLES(MIN),
    .SETTLE_CYCLES   (SET),
    .BOUNCE_TOGGLES  (TOG),
    .BOUNCE_PERIOD   (PER),
    .CNT_WIDTH       (CW)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .osw_drive0 (osw_drive0),
    .osw_drive1 (osw_drive1),
    .osw_status0(osw_status0),
    .osw_status1(osw_status1),
    .sw_position(sw_position),
    .pos_valid  (pos_valid),
    .sw_busy    (sw_busy),
    .drive_fault(drive_fault),
    .act_count  (act_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the run length of qualified drive, and the time since the last actuation started.
  int          m_run;
  logic        m_lane;
  logic        m_pos;
  logic        m_pv;
  logic        m_busy;
  int          m_t;
  logic        m_fault;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_lane = 1'b0; m_pos = 1'b0; m_pv = 1'b0;
    m_busy = 1'b0; m_t = MOTION_LEN; m_fault = 1'b0; m_cnt = 16'h0;
  endtask

  // Level of the target contact m_t cycles after the actuation started.
  function automatic logic exp_level(input int t);
    int u;
    if (t < SET) return 1'b0;
    u = t - SET;
    if (TOG == 0 || u >= PER * (TOG + 1)) return 1'b1;
    return ((u / PER) % 2) == 0;
  endfunction

  task automatic model_edge(input logic d0, input logic d1);
    if (d0 && d1) m_fault = 1'b1;
    if (m_busy) begin
      m_t++;
      if (m_t == MOTION_LEN) m_busy = 1'b0;
      m_run = 0;
    end else if (d0 != d1) begin
      if (m_run > 0 && d1 != m_lane) begin
        m_run = 0;
      end else begin
        m_run++;
        m_lane = d1;
        if (m_run == MIN) begin
          m_run = 0;
          if (!(m_pv && m_pos == d0)) begin
            m_pos = d0; m_pv = 1'b1; m_busy = 1'b1; m_t = 0;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          end
        end
      end
    end else begin
      m_run = 0;
    end
  endtask

  function automatic logic [31:0] outs();
    return {10'b0, osw_status0, osw_status1, sw_position, pos_valid, sw_busy, drive_fault, act_count};
  endfunction

  function automatic logic [31:0] exp_outs();
    logic lvl;
    lvl = m_pv && exp_level(m_t);
    return {10'b0, lvl && m_pos, lvl && !m_pos, m_pos, m_pv, m_busy, m_fault, m_cnt};
  endfunction

  // Apply one cycle of drive and compare all outputs with the model.
  task automatic step(input logic d0, input logic d1);
    osw_drive0 = d0;
    osw_drive1 = d1;
    @(posedge aclk);
    model_edge(d0, d1);
    @(negedge aclk);
    check("cycle_outs", outs(), exp_outs());
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < MOTION_LEN + 4; i++) begin
      if (!m_busy) break;
      step(1'b0, 1'b0);
    end
    check(tag, {31'b0, sw_busy}, 32'd0);
  endtask

  task automatic actuate(input logic on, input string tag);
    for (int i = 0; i < MIN; i++) step(on, !on);
    wait_idle(tag);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    @(negedge aclk);
    model_reset();
    check("reset_outs", outs(), 32'd0);
    areset = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    osw_drive0 = 1'b0;
    osw_drive1 = 1'b0;
    model_reset();
    repeat (2) @(negedge aclk);
    do_reset();

    // Drive held one cycle short of qualification must not actuate.
    for (int i = 0; i < MIN - 1; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    check("t2_busy", {31'b0, sw_busy}, 32'd0);
    check("t2_status", {30'b0, osw_status0, osw_status1}, 32'd0);
    check("t2_act", {16'b0, act_count}, 32'd0);

    // First full actuation toward ON, with exact settle timing.
    for (int i = 0; i < MIN; i++) step(1'b1, 1'b0);
    check("t1_move_busy", {31'b0, sw_busy}, 32'd1);
    check("t1_move_status", {30'b0, osw_status0, osw_status1}, 32'd0);
    for (int i = 0; i < SET - 1; i++) step(1'b0, 1'b0);
    check("t1_settle_low", {30'b0, osw_status0, osw_status1}, 32'd0);
    step(1'b0, 1'b0);
    check("t1_rise", {30'b0, osw_status0, osw_status1}, 32'd2);
    wait_idle("t1_idle");
    check("t1_final", {29'b0, osw_status0, osw_status1, sw_position}, 32'b101);
    check("t1_act", {16'b0, act_count}, 32'd1);

    // Driving toward the position already latched is a no-op. Then move to OFF.
    actuate(1'b1, "t3_noop_idle");
    check("t3_noop_act", {16'b0, act_count}, 32'd1);
    check("t3_noop_status", {30'b0, osw_status0, osw_status1}, 32'd2);
    for (int i = 0; i < MIN; i++) step(1'b0, 1'b1);
    check("t3_drop", {30'b0, osw_status0, osw_status1}, 32'd0);
    wait_idle("t3_idle");
    check("t3_status1", {30'b0, osw_status0, osw_status1}, 32'd1);
    check("t3_act", {16'b0, act_count}, 32'd2);

    // Both lanes together set a sticky fault that survives later actuations.
    step(1'b1, 1'b1);
    check("t4_fault", {31'b0, drive_fault}, 32'd1);
    actuate(1'b1, "t4_idle");
    check("t4_fault_sticky", {31'b0, drive_fault}, 32'd1);
    check("t4_act", {16'b0, act_count}, 32'd3);

    // A reversed drive during motion is ignored. Then a reset is asserted in the middle of a bounce.
    actuate(1'b0, "t5_off_idle");
    for (int i = 0; i < MIN; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
    wait_idle("t5_idle");
    check("t5_pos_on", {30'b0, sw_position, osw_status0}, 32'd3);
    check("t5_act", {16'b0, act_count}, 32'd5);
    for (int i = 0; i < MIN; i++) step(1'b0, 1'b1);
    for (int i = 0; i < SET + 7; i++) step(1'b0, 1'b0);
    check("t5_in_bounce", {31'b0, sw_busy}, 32'd1);
    #1 areset = 1'b1;
    #1 check("t5_async_rst", outs(), 32'd0);
    @(negedge aclk);
    model_reset();
    areset = 1'b0;

    // Randomized drive patterns compared cycle by cycle with the model.
    for (int seg = 0; seg < 60; seg++) begin
      int sel;
      int len;
      logic d0;
      logic d1;
      sel = $urandom_range(0, 19);
      len = $urandom_range(1, MIN + 8);
      d0 = (sel >= 2 && sel <= 9) || sel == 19;
      d1 = (sel >= 10 && sel <= 18) || sel == 19;
      if (sel == 19) len = 1;
      for (int i = 0; i < len; i++) step(d0, d1);
      if (seg == 30) do_reset();
    end
    wait_idle("rand_idle");

    // Saturation of the actuation counter.
    @(negedge aclk);
    force dut.act_count_q = 16'hFFFE;
    #1 release dut.act_count_q;
    m_cnt = 16'hFFFE;
    actuate(!m_pos, "t6_idle_a");
    check("t6_act_ffff", {16'b0, act_count}, 32'h0000FFFF);
    actuate(!m_pos, "t6_idle_b");
    check("t6_act_sat", {16'b0, act_count}, 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
